// File: rtl/lcd_pkg.sv
// Shared types and timing defaults for the character LCD reader/writer pair.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE, SETUP, E_UP, GAP, E_LO, HOLD, PGAP, DONE
  } lcd_state_t;

  // Default bus timing at 50 MHz, shared with the writer side
  localparam int DEF_SETUP_CYCLES      = 2;
  localparam int DEF_E_HIGH_CYCLES     = 12;
  localparam int DEF_NIBBLE_GAP_CYCLES = 50;
  localparam int DEF_POLL_TIMEOUT      = 1000000;

  localparam int   BF_BIT  = 7;
  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable 8-bit down-counter; expired while the count sits at zero.
module lcd_phase_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] value,
  output logic       expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)          cnt <= 8'd0;
    else if (load)       cnt <= value;
    else if (cnt != 8'd0) cnt <= cnt - 8'd1;
  end

  assign expired = (cnt == 8'd0);

endmodule

// File: rtl/lcd_reader.sv
// HD44780 4-bit read engine: busy/address or data reads, optional busy-flag polling.
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int SETUP_CYCLES      = DEF_SETUP_CYCLES,
  parameter int E_HIGH_CYCLES     = DEF_E_HIGH_CYCLES,
  parameter int NIBBLE_GAP_CYCLES = DEF_NIBBLE_GAP_CYCLES,
  parameter int POLL_TIMEOUT      = DEF_POLL_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        rs_sel,
  input  logic        poll,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        timeout,
  input  logic [11:8] SF_D,
  output logic        LCD_E,
  output logic        LCD_RS,
  output logic        LCD_RW
);

  localparam logic [7:0]  SETUP_LD = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0]  EHI_LD   = 8'(E_HIGH_CYCLES - 1);
  localparam logic [7:0]  GAP_LD   = 8'(NIBBLE_GAP_CYCLES - 1);
  localparam logic [19:0] TO_LIM   = 20'(POLL_TIMEOUT);

  lcd_state_t  state, state_next;
  logic        rs_q, poll_q, rs_cur, busy_next;
  logic [7:0]  rdata_next;
  logic [19:0] tcnt;
  logic        load, expired, timed_out, poll_again;
  logic [7:0]  load_val;

  lcd_phase_timer u_phase (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .value   (load_val),
    .expired (expired)
  );

  assign timed_out  = poll_q && rdata_next[BF_BIT] && (tcnt >= TO_LIM);
  assign poll_again = poll_q && rdata_next[BF_BIT] && (tcnt < TO_LIM);

  always_comb begin
    state_next = state;
    load_val   = 8'd0;
    case (state)
      IDLE:    if (req)     state_next = SETUP;
      SETUP:   if (expired) state_next = E_UP;
      E_UP:    if (expired) state_next = GAP;
      GAP:     if (expired) state_next = E_LO;
      E_LO:    if (expired) state_next = HOLD;
      HOLD:    state_next = poll_again ? PGAP : DONE;
      PGAP:    if (expired) state_next = E_UP;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Every state entry reloads the phase timer with its length minus one
    load = (state_next != state);
    case (state_next)
      SETUP:      load_val = SETUP_LD;
      E_UP, E_LO: load_val = EHI_LD;
      GAP, PGAP:  load_val = GAP_LD;
      default:    load_val = 8'd0;
    endcase
    busy_next = (state_next != IDLE) && (state_next != DONE);
    rs_cur    = (state == IDLE) ? (poll ? RS_CMD : rs_sel) : rs_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rs_q       <= RS_CMD;
      poll_q     <= 1'b0;
      rdata_next <= 8'h00;
      tcnt       <= 20'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rdata      <= 8'h00;
      timeout    <= 1'b0;
      LCD_E      <= 1'b0;
      LCD_RS     <= 1'b0;
      LCD_RW     <= 1'b0;
    end else begin
      state  <= state_next;
      busy   <= busy_next;
      done   <= (state_next == DONE);
      LCD_E  <= (state_next == E_UP) || (state_next == E_LO);
      LCD_RW <= busy_next;
      LCD_RS <= busy_next & rs_cur;
      if (state == IDLE && req) begin
        rs_q    <= rs_cur;
        poll_q  <= poll;
        tcnt    <= 20'd0;
        timeout <= 1'b0;
      end else if (busy && tcnt != 20'hFFFFF) begin
        tcnt <= tcnt + 20'd1;
      end
      // Sample on the last E-high cycle so the LCD output has settled
      if (state == E_UP && expired) rdata_next[7:4] <= SF_D;
      if (state == E_LO && expired) rdata_next[3:0] <= SF_D;
      if (state_next == DONE) begin
        rdata   <= rdata_next;
        timeout <= timed_out;
      end
    end
  end

endmodule

// File: tb/tb_lcd_reader.sv
// Scoreboard bench for lcd_reader with a nibble-serving LCD model and E timing monitor.
module tb_lcd_reader;

  logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0, rs_sel = 1'b0, poll = 1'b0;
  logic        busy, done, timeout, lcd_e, lcd_rs, lcd_rw;
  logic [7:0]  rdata;
  logic [11:8] sf_d = 4'h0;

  typedef struct {
    logic [7:0] data;
    logic       to;
    int         lat;
    int         pulses;
    logic       rs;
  } exp_t;

  exp_t       sb[$];
  exp_t       ex;
  logic [7:0] mq[$];
  logic [7:0] cur = 8'h00;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int e_hi = 0, e_lo = 0, pidx = 0, rsrw_bad = 0;
  int acc_cyc = 0, acc_cnt = 0, done_cnt = 0, done_cyc = 0;
  logic e_prev = 1'b0, busy_prev = 1'b0, exp_rs = 1'b0;

  lcd_reader #(.POLL_TIMEOUT(500)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rs_sel(rs_sel), .poll(poll),
    .busy(busy), .done(done), .rdata(rdata), .timeout(timeout),
    .SF_D(sf_d), .LCD_E(lcd_e), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // LCD model serves {upper,lower} nibbles per E pair; monitor checks timing and done
  always @(negedge clk) begin
    if (!rst_n) begin
      e_hi = 0; e_lo = 0; pidx = 0; rsrw_bad = 0; e_prev = 1'b0; busy_prev = 1'b0;
    end else begin
      if (busy && !busy_prev) begin
        acc_cyc = cyc; acc_cnt++; pidx = 0; e_lo = 0; e_hi = 0; rsrw_bad = 0;
        exp_rs = (sb.size() > 0) ? sb[0].rs : 1'b0;
      end
      if (busy && (lcd_rw !== 1'b1 || lcd_rs !== exp_rs)) rsrw_bad++;
      if (lcd_e) begin
        if (!e_prev) begin
          if (pidx == 0) chk("setup_len", e_lo, 2);
          else           chk("gap_len", e_lo, (pidx % 2 == 1) ? 50 : 51);
          e_lo = 0;
          if (pidx % 2 == 0) begin
            cur  = (mq.size() > 1) ? mq.pop_front() : ((mq.size() == 1) ? mq[0] : 8'h00);
            sf_d = cur[7:4];
          end else begin
            sf_d = cur[3:0];
          end
        end
        e_hi++;
      end else begin
        if (e_prev) begin
          chk("e_len", e_hi, 12);
          e_hi = 0;
          pidx++;
        end
        if (busy) e_lo++;
      end
      if (done) begin
        done_cnt++; done_cyc = cyc;
        chk("done_busy", busy, 0);
        chk("done_rw", lcd_rw, 0);
        chk("done_rs", lcd_rs, 0);
        if (sb.size() == 0) chk("spurious_done", sb.size(), 1);
        else begin
          ex = sb.pop_front();
          chk("rdata", rdata, ex.data);
          chk("timeout", timeout, ex.to);
          chk("pulses", pidx, ex.pulses);
          chk("rs_rw_hold", rsrw_bad, 0);
          if (ex.lat > 0) chk("latency", cyc - acc_cyc, ex.lat);
        end
      end
      e_prev = lcd_e; busy_prev = busy;
    end
  end

  task automatic push_exp(input logic r, input logic p, input logic [7:0] d,
                          input logic t, input int lat, input int np);
    exp_t x;
    x.data = d; x.to = t; x.lat = lat; x.pulses = np; x.rs = p ? 1'b0 : r;
    sb.push_back(x);
  endtask

  task automatic issue(input logic r, input logic p, input logic [7:0] d,
                       input logic t, input int lat, input int np);
    push_exp(r, p, d, t, lat, np);
    @(negedge clk); rs_sel = r; poll = p; req = 1'b1;
    @(negedge clk); req = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int s = done_cnt;
    for (int i = 0; i < lim && done_cnt == s; i++) @(posedge clk);
    chk("done_seen", done_cnt - s, 1);
    @(negedge clk);
  endtask

  initial begin
    int s, a0, d0;
    repeat (3) @(negedge clk);
    chk("rst_e", lcd_e, 0);   chk("rst_rs", lcd_rs, 0); chk("rst_rw", lcd_rw, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 8'h00); chk("rst_timeout", timeout, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Data read and busy/address read
    mq.delete(); mq.push_back(8'h41);
    issue(1'b1, 1'b0, 8'h41, 1'b0, 77, 2); wait_done(200);
    mq.delete(); mq.push_back(8'h85);
    issue(1'b0, 1'b0, 8'h85, 1'b0, 77, 2); wait_done(200);

    // Poll: three busy reads then ready; rs_sel must be ignored
    mq = '{8'h80, 8'h80, 8'h80, 8'h03};
    issue(1'b1, 1'b1, 8'h03, 1'b0, 0, 8); wait_done(1000);

    // Poll timeout with BF stuck high
    mq.delete(); mq.push_back(8'h80);
    issue(1'b0, 1'b1, 8'h80, 1'b1, 0, 10); wait_done(2000);
    @(negedge clk);
    chk("rw_after_done", lcd_rw, 0);

    // Reset inside the first E pulse
    mq.delete(); mq.push_back(8'h41);
    issue(1'b1, 1'b0, 8'h41, 1'b0, 77, 2);
    for (int i = 0; i < 100 && !lcd_e; i++) @(negedge clk);
    chk("e_seen", lcd_e, 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_e", lcd_e, 0);   chk("mid_rst_rw", lcd_rw, 0);
    chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0);
    repeat (2) @(negedge clk);
    sb.delete(); rst_n = 1'b1;
    s = done_cnt;
    repeat (100) @(negedge clk);
    chk("no_done_after_rst", done_cnt - s, 0);
    issue(1'b1, 1'b0, 8'h41, 1'b0, 77, 2); wait_done(200);

    // req held high with an extra pulse mid-transaction
    mq = '{8'h41, 8'h85};
    push_exp(1'b1, 1'b0, 8'h41, 1'b0, 77, 2);
    push_exp(1'b1, 1'b0, 8'h85, 1'b0, 77, 2);
    a0 = acc_cnt;
    @(negedge clk); rs_sel = 1'b1; poll = 1'b0; req = 1'b1;
    for (int i = 0; i < 10 && acc_cnt == a0; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    req = 1'b0; @(negedge clk); req = 1'b1;
    wait_done(200);
    d0 = done_cyc; a0 = acc_cnt;
    for (int i = 0; i < 10 && acc_cnt == a0; i++) @(negedge clk);
    req = 1'b0;
    chk("reaccept", acc_cyc - d0, 2);
    wait_done(200);
    repeat (100) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
